// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Shares one UART transmitter among NREQ byte-stream requesters. The
// arbitration is round-robin and locked to frames. A granted requester keeps
// the transmitter until it sends a byte marked "last", or until its req
// stays low for too long (IDLE_TO cycles in LOCK).
//
// Handshakes:
//   requester i -> arbiter : req[i]/req_data/req_last are a valid/ready pair.
//                            The byte is consumed in the cycle ack[i] is high.
//                            The requester may change the byte on the next cycle.
//   arbiter -> uart_tx     : tx_en is a one-cycle strobe. It is issued only
//                            after tx_rdy was seen high in LOCK. The arbiter
//                            then waits in BUSY until tx_rdy returns high.
//
// Ports:
//   clk, rst_n   clock; synchronous active-low reset
//   req          per-requester "byte available"
//   req_data     byte for requester i on [8*i+7:8*i]
//   req_last     byte on req_data ends the frame
//   ack          one-cycle pulse: requester i's byte taken
//   grant        one-hot current owner, zero when unowned
//   busy         a frame lock is held
//   tx_data      byte to uart_tx.data_out
//   tx_en        send strobe to uart_tx.en
//   tx_rdy       uart_tx.rdy, high when the transmitter is idle
//   dbg_state    current FSM state (0 IDLE, 1 LOCK, 2 SEND, 3 BUSY)
//   dbg_ptr      round-robin search start index
// ---------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int NREQ    = 4,
    parameter int IDLE_TO = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    input  logic                 tx_rdy,
    output logic [1:0]           dbg_state,
    output logic [2:0]           dbg_ptr
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_SEND = 2'd2,
        ST_BUSY = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;

    logic [IW-1:0]     pick;
    logic              found;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     owner_next;
    logic              held;
    logic [NREQ-1:0]   owner_oh;

    // Owner index plus one, wrapping at NREQ; becomes the next search start.
    assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Round-robin search: the first high req at or after ptr, wrapping.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tx_data_d = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d = pick;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // A send takes priority over an idle revoke in the same cycle.
                if (req[owner_q] && tx_rdy) begin
                    tx_data_d = req_data[{owner_q, 3'b000} +: 8];
                    last_d    = req_last[owner_q];
                    cnt_d     = '0;
                    state_d   = ST_SEND;
                end else if (!req[owner_q]) begin
                    if (cnt_q >= 16'(IDLE_TO)) begin
                        cnt_d   = '0;
                        ptr_d   = owner_next;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_SEND: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // tx_rdy is low on entry because uart_tx drops rdy after en.
                if (tx_rdy) begin
                    if (last_q) begin
                        ptr_d   = owner_next;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The outputs are registered from the next state, so they change in the
    // same cycle that the state changes.
    always_comb begin
        held     = (state_d != ST_IDLE);
        owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_d;
        grant_d  = held ? owner_oh : '0;
        busy_d   = held;
        tx_en_d  = (state_d == ST_SEND);
        ack_d    = (state_d == ST_SEND) ? owner_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            ack_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign tx_data   = tx_data_q;
    assign tx_en     = tx_en_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = 3'(ptr_q);

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Bench for uart_tx_arb with NREQ=4 and IDLE_TO=8. A behavioural uart_tx
// model (random byte time) drives tx_rdy and logs every accepted byte
// together with the ack vector. Directed steps cover the single byte,
// round-robin, frame lock, idle revoke, mid-frame reset and flow control.
// Random rounds are checked against a frame-level round-robin model.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int NREQ    = 4;
    localparam int IDLE_TO = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req      = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              tx_rdy;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_ptr;

    uart_tx_arb #(.NREQ(NREQ), .IDLE_TO(IDLE_TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .ack       (ack),
        .grant     (grant),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_rdy    (tx_rdy),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // ---------------- uart_tx model and byte log ----------------
    logic u_rdy    = 1'b1;
    int   u_cnt    = 0;
    logic rdy_hold = 1'b0;
    int   blen_lo  = 2;
    int   blen_hi  = 6;
    int   viol_en  = 0;
    int   viol_ack = 0;
    logic [NREQ+7:0] obs_q[$];

    assign tx_rdy = u_rdy & ~rdy_hold;

    always @(posedge clk) begin
        if (tx_en) begin
            if (!tx_rdy) viol_en <= viol_en + 1;
            if (!$onehot(ack)) viol_ack <= viol_ack + 1;
            obs_q.push_back({ack, tx_data});
            u_rdy <= 1'b0;
            u_cnt <= int'($urandom_range(blen_hi, blen_lo));
        end else begin
            if (ack != '0) viol_ack <= viol_ack + 1;
            if (!u_rdy) begin
                if (u_cnt <= 1) u_rdy <= 1'b1;
                else u_cnt <= u_cnt - 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [NREQ+7:0] exp_q[$];
    logic [8:0]      rq_q[NREQ][$];   // per requester: {last, byte}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int k = 0;
        while (dbg_state !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(dbg_state), 32'(s));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        req_last = '0;
        rdy_hold = 1'b0;
        for (int i = 0; i < NREQ; i++) rq_q[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic bit q_empty();
        for (int i = 0; i < NREQ; i++)
            if (rq_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One cycle of the requester driver: retire acked bytes, present heads.
    task automatic auto_step();
        for (int i = 0; i < NREQ; i++)
            if (ack[i] && rq_q[i].size() > 0) void'(rq_q[i].pop_front());
        for (int i = 0; i < NREQ; i++) begin
            req[i]            = (rq_q[i].size() > 0);
            req_data[8*i +: 8] = (rq_q[i].size() > 0) ? rq_q[i][0][7:0] : 8'h00;
            req_last[i]       = (rq_q[i].size() > 0) ? rq_q[i][0][8] : 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_auto(input int budget, input string tag);
        int k = 0;
        while (!(q_empty() && req == '0 && dbg_state == 2'd0) && k < budget) begin
            auto_step();
            k++;
        end
        check(tag, {31'd0, (q_empty() && dbg_state == 2'd0)}, 32'd1);
    endtask

    // Frame-level model: starting at p, serve whole frames from the first
    // requester (cyclically) that has one pending; the next search starts
    // just after that requester.
    task automatic build_expect(input int p0, output int p_end);
        logic [8:0] mq[NREQ][$];
        logic [8:0] b;
        int p;
        int o;
        p = p0;
        for (int i = 0; i < NREQ; i++) mq[i] = rq_q[i];
        while (1) begin
            o = -1;
            for (int k = 0; k < NREQ; k++)
                if (o < 0 && mq[(p + k) % NREQ].size() > 0) o = (p + k) % NREQ;
            if (o < 0) break;
            do begin
                b = mq[o].pop_front();
                exp_q.push_back({NREQ'(1 << o), b[7:0]});
            end while (!b[8] && mq[o].size() > 0);
            p = (o + 1) % NREQ;
        end
        p_end = p;
    endtask

    task automatic compare_obs(input int base, input string tag);
        check({tag, "_count"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < obs_q.size())
                check($sformatf("%s[%0d]", tag, i), 32'(obs_q[base + i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    // ---------------- directed and random steps ----------------
    initial begin
        int base;
        int p;
        int p_next;
        int nf;
        int nb;
        int k;

        // Reset state
        cyc(2);
        do_reset();
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_ptr", 32'(dbg_ptr), 32'd0);

        // Single byte from requester 2
        base = obs_q.size();
        req[2] = 1'b1;
        req_data[23:16] = 8'hA5;
        req_last[2] = 1'b1;
        cyc();
        check("sb_grant_c1", 32'(grant), 32'b0100);
        check("sb_busy_c1", 32'(busy), 32'd1);
        check("sb_tx_en_c1", 32'(tx_en), 32'd0);
        cyc();
        check("sb_tx_en_c2", 32'(tx_en), 32'd1);
        check("sb_tx_data_c2", 32'(tx_data), 32'hA5);
        check("sb_ack_c2", 32'(ack), 32'b0100);
        req = '0;
        cyc();
        check("sb_pulse_end", 32'({tx_en, ack}), 32'd0);
        wait_state(2'd0, 50, "sb_idle");
        check("sb_grant_end", 32'(grant), 32'd0);
        check("sb_busy_end", 32'(busy), 32'd0);
        check("sb_ptr", 32'(dbg_ptr), 32'd3);
        exp_q.push_back({4'b0100, 8'hA5});
        compare_obs(base, "sb_log");

        // Round-robin with all requesters asserting
        do_reset();
        base = obs_q.size();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) rq_q[i].push_back({1'b1, 8'(8'h10 + i)});
        for (int j = 0; j < 8; j++) exp_q.push_back({NREQ'(1 << (j % NREQ)), 8'(8'h10 + (j % NREQ))});
        run_auto(500, "rr_done");
        compare_obs(base, "rr_log");
        check("rr_ack_per_en", 32'(viol_ack), 32'd0);

        // Frame lock: requester 1 owns, requester 0 must wait
        base = obs_q.size();
        rq_q[1].push_back({1'b0, 8'h01});
        rq_q[1].push_back({1'b0, 8'h02});
        rq_q[1].push_back({1'b1, 8'h03});
        auto_step();
        check("fl_grant1", 32'(grant), 32'b0010);
        rq_q[0].push_back({1'b1, 8'h55});
        run_auto(500, "fl_done");
        exp_q.push_back({4'b0010, 8'h01});
        exp_q.push_back({4'b0010, 8'h02});
        exp_q.push_back({4'b0010, 8'h03});
        exp_q.push_back({4'b0001, 8'h55});
        compare_obs(base, "fl_log");
        check("fl_ptr", 32'(dbg_ptr), 32'd1);

        // Idle revoke of requester 0 while requester 3 waits
        do_reset();
        base = obs_q.size();
        req = 4'b1001;
        req_data[7:0] = 8'h77;
        req_last[0] = 1'b0;
        req_data[31:24] = 8'h33;
        req_last[3] = 1'b1;
        cyc();
        check("rv_grant0", 32'(grant), 32'b0001);
        cyc();
        check("rv_ack0", 32'(ack), 32'b0001);
        req[0] = 1'b0;
        cyc();
        wait_state(2'd1, 50, "rv_lock");
        check("rv_hold_c0", 32'(grant), 32'b0001);
        cyc(IDLE_TO);
        check("rv_hold_last", 32'(grant), 32'b0001);
        cyc();
        check("rv_drop", 32'(grant), 32'b0000);
        cyc();
        check("rv_grant3", 32'(grant), 32'b1000);
        cyc();
        check("rv_ack3", 32'(ack), 32'b1000);
        check("rv_data3", 32'(tx_data), 32'h33);
        req = '0;
        wait_state(2'd0, 50, "rv_idle");
        check("rv_ptr", 32'(dbg_ptr), 32'd0);
        exp_q.push_back({4'b0001, 8'h77});
        exp_q.push_back({4'b1000, 8'h33});
        compare_obs(base, "rv_log");

        // Reset during BUSY with a slow transmitter
        blen_lo = 20;
        blen_hi = 20;
        req[1] = 1'b1;
        req_data[15:8] = 8'h44;
        req_last[1] = 1'b0;
        cyc(2);
        req_data[15:8] = 8'h45;
        req_last[1] = 1'b1;
        cyc();
        check("rm_busy", 32'(dbg_state), 32'd3);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("rm_grant", 32'(grant), 32'd0);
        check("rm_busy_out", 32'(busy), 32'd0);
        check("rm_tx_en", 32'(tx_en), 32'd0);
        check("rm_ptr", 32'(dbg_ptr), 32'd0);
        k = 0;
        while (!tx_en && k < 80) begin
            cyc();
            k++;
        end
        check("rm_resend", 32'(tx_en), 32'd1);
        check("rm_data", 32'(tx_data), 32'h45);
        check("rm_ack", 32'(ack), 32'b0010);
        check("rm_no_en_while_low", 32'(viol_en), 32'd0);
        req = '0;
        wait_state(2'd0, 80, "rm_idle");
        blen_lo = 2;
        blen_hi = 6;

        // Flow control: tx_rdy held low while the owner requests
        rdy_hold = 1'b1;
        req[2] = 1'b1;
        req_data[23:16] = 8'h99;
        req_last[2] = 1'b1;
        cyc();
        check("fc_grant", 32'(grant), 32'b0100);
        for (int j = 0; j < IDLE_TO + 4; j++) begin
            cyc();
            check($sformatf("fc_quiet[%0d]", j), 32'({tx_en, ack}), 32'd0);
        end
        check("fc_grant_kept", 32'(grant), 32'b0100);
        rdy_hold = 1'b0;
        cyc();
        check("fc_tx_en", 32'(tx_en), 32'd1);
        check("fc_data", 32'(tx_data), 32'h99);
        check("fc_ack", 32'(ack), 32'b0100);
        req = '0;
        wait_state(2'd0, 50, "fc_idle");
        check("fc_ptr", 32'(dbg_ptr), 32'd3);

        // Random frames against the frame-level model
        do_reset();
        p = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                nf = int'($urandom_range(3, 0));
                for (int f = 0; f < nf; f++) begin
                    nb = int'($urandom_range(3, 1));
                    for (int b = 0; b < nb; b++)
                        rq_q[i].push_back({(b == nb - 1), 8'($urandom)});
                end
            end
            build_expect(p, p_next);
            p = p_next;
            base = obs_q.size();
            run_auto(3000, $sformatf("rnd%0d_done", r));
            compare_obs(base, $sformatf("rnd%0d_log", r));
            check($sformatf("rnd%0d_ptr", r), 32'(dbg_ptr), 32'(p));
        end
        check("proto_en_while_low", 32'(viol_en), 32'd0);
        check("proto_ack_per_en", 32'(viol_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one UART transmitter among `NREQ` byte-stream requesters with frame locking. It sits between the internal byte sources (command responder, debug/log, sniffer upload, and so on) and the `uart_tx` instance. It drives `uart_tx`'s `en`/`data_out` and watches its `rdy`. A granted requester keeps the transmitter until it sends a byte marked `last`, or until it stays idle for `IDLE_TO` cycles.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDLE_TO`, 1000: cycles a locked owner may hold `req` low before its lock is revoked, 1..65535.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req`  in  NREQ  per-requester "byte available"
- `req_data`  in  8*NREQ  byte for requester i on `[8*i+7:8*i]`
- `req_last`  in  NREQ  byte on `req_data` ends the frame
- `ack`  out  NREQ  one-cycle pulse: requester i's byte taken
- `grant`  out  NREQ  one-hot current owner; all zero when unowned
- `busy`  out  1  a frame lock is held
- `tx_data`  out  8  to `uart_tx.data_out`
- `tx_en`  out  1  to `uart_tx.en`
- `tx_rdy`  in  1  from `uart_tx.rdy`; high when the transmitter is idle

## Operation
- Reset (`rst_n`=0 at a clk edge) sets: state IDLE, `grant`=0, `ack`=0, `busy`=0, `tx_en`=0, `tx_data`=0x00, round-robin pointer `ptr`=0, idle counter=0. Reset mid-frame aborts the frame. The transmitter may still be finishing a byte; that is harmless because the next send waits for `tx_rdy`.
- **IDLE**
  - If any `req` is high, search from index `ptr` upward, wrapping at NREQ. The first high index becomes the owner.
  - Next state is LOCK; `grant` becomes one-hot of the owner and `busy`=1.
- **LOCK**
  - If `req[owner]` and `tx_rdy` are both high:
    - Register `tx_data` ← `req_data[owner]` and latch `last` ← `req_last[owner]`.
    - Clear the idle counter and go to SEND.
  - Else if `req[owner]` is low:
    - Increment the idle counter.
    - When the counter reaches `IDLE_TO`, release: `ptr` ← owner+1 (mod NREQ), go to IDLE.
  - Else (`req` high, `tx_rdy` low): hold, and clear the idle counter.
- **SEND** (exactly one cycle)
  - `tx_en`=1 and `ack[owner]`=1.
  - The requester may present its next byte in the following cycle.
  - Next state is BUSY.
- **BUSY**
  - `tx_en`=0.
  - Wait for `tx_rdy`=1. It is guaranteed low on BUSY entry, because `uart_tx` drops `rdy` the cycle after sampling `en`.
  - On `tx_rdy`=1: if `last`, release (`ptr` ← owner+1 mod NREQ) and go to IDLE; otherwise go to LOCK.
- `grant`/`busy` are high in LOCK, SEND and BUSY; they drop in the same cycle the state enters IDLE.
- `ack` and `tx_en` are registered outputs and are high only in SEND.
- Requesters other than the owner are ignored (no `ack`) while a lock is held. Their `req` stays pending.
- Changes to `req`/`req_data` of the owner during BUSY are ignored until LOCK.
- The arbiter never issues `tx_en` while `tx_rdy`=0.
- The state encoding is 2 bits. Any illegal value recovers to IDLE.

## Timing
- Latency with the transmitter idle: `req` high in IDLE at cycle 0 → `grant` at cycle 1 → `tx_en`/`ack` at cycle 2.
- Back-to-back bytes within a frame: the next `tx_en` comes 2 cycles after `tx_rdy` rises (BUSY→LOCK→SEND). Per-byte overhead is therefore 2 cycles beyond the `uart_tx` idle-to-idle period.
- Owner handover after a `last` byte: the next owner's `tx_en` comes 3 cycles after `tx_rdy` rises (BUSY→IDLE→LOCK→SEND).
- Idle revoke: the release happens at the edge where the counter reaches `IDLE_TO`. The owner loses `grant` exactly `IDLE_TO`+1 cycles after the first LOCK cycle with `req` low.
- Simultaneous `req` from all requesters: service order is `ptr`, `ptr`+1, … wrapping. No requester waits more than NREQ−1 frames.
- If `req[owner]` and `tx_rdy` rise in the same LOCK cycle as the counter would hit `IDLE_TO`, the send wins and the counter clears.

## Test plan
- **Single byte.** Reset, then `req[2]`=1 with `req_data[2]`=0xA5 and `req_last[2]`=1. Required: `grant`=0b0100 at cycle 1; `tx_en`=1, `tx_data`=0xA5 and `ack[2]`=1 at cycle 2 for one cycle. After `uart_tx` finishes, `grant`=0 and `ptr`=3.
- **Round-robin.** Hold `req`=0b1111 continuously, every requester sending single-byte frames with data 0x10+i. Required: transmitted bytes 0x10, 0x11, 0x12, 0x13, 0x10, …, with exactly one `ack` per `tx_en`.
- **Frame lock.** `req[1]` sends a 3-byte frame 0x01, 0x02, 0x03 (last on the third byte) while `req[0]` is held high. Required: all three bytes of requester 1 are transmitted before any byte of requester 0, and `ack[0]` stays 0 until requester 1 releases.
- **Idle revoke.** Use `IDLE_TO`=8. Requester 0 sends one non-last byte and then drops `req`, while `req[3]`=1. Required: `grant[0]` falls 9 cycles after requester 0's first low-`req` LOCK cycle, and `grant[3]` rises one cycle later.
- **Reset mid-frame.** Pull `rst_n` low for one cycle during BUSY. Required: next cycle `grant`=0, `busy`=0, `tx_en`=0 and `ptr`=0. A new request is sent only after `tx_rdy` returns high.
- **Flow control.** Hold `tx_rdy` low while the owner asserts `req`. Required: no `tx_en` and no `ack`, and the idle counter does not advance. The byte goes out 1 cycle after `tx_rdy` rises.
